// File: rtl/sc_point_request_scheduler_pkg.sv
// Shared types and constants for the point request scheduler slice:
// arbiter state encoding, request source indices and the priority pick.
package sc_point_request_scheduler_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE_0  = 2'd0,
    STATE_GRANT_0 = 2'd1,
    STATE_GAP_0   = 2'd2
  } sched_state_t;

  typedef logic [1:0] src_idx_t;

  // Source indices double as bit positions in the pending/request vectors.
  localparam src_idx_t SRC_START = 2'd0;
  localparam src_idx_t SRC_LEFT  = 2'd1;
  localparam src_idx_t SRC_RIGHT = 2'd2;
  localparam src_idx_t SRC_TICK  = 2'd3;

  // Fixed priority start > left > right > tick; only meaningful when pend != 0.
  function automatic src_idx_t pick_winner(input logic [3:0] pend);
    if (pend[0])      return SRC_START;
    else if (pend[1]) return SRC_LEFT;
    else if (pend[2]) return SRC_RIGHT;
    else              return SRC_TICK;
  endfunction

endpackage

// File: rtl/sc_point_request_scheduler_if.sv
// Board-side inputs and state-machine-side request outputs of the scheduler.
// master = whoever drives the raw buttons and reads the requests,
// slave  = the scheduler itself.
interface sc_point_request_scheduler_if;

  logic SC_SCHED_startButton_InLow;
  logic SC_SCHED_leftButton_InLow;
  logic SC_SCHED_rightButton_InLow;
  logic SC_SCHED_tickEnable_InHigh;
  logic SC_SCHED_startButton_OutLow;
  logic SC_SCHED_leftButton_OutLow;
  logic SC_SCHED_rightButton_OutLow;
  logic SC_SCHED_T0_OutLow;
  logic SC_SCHED_busy_OutHigh;
  logic SC_SCHED_overrun_OutHigh;

  modport master (
    output SC_SCHED_startButton_InLow,
    output SC_SCHED_leftButton_InLow,
    output SC_SCHED_rightButton_InLow,
    output SC_SCHED_tickEnable_InHigh,
    input  SC_SCHED_startButton_OutLow,
    input  SC_SCHED_leftButton_OutLow,
    input  SC_SCHED_rightButton_OutLow,
    input  SC_SCHED_T0_OutLow,
    input  SC_SCHED_busy_OutHigh,
    input  SC_SCHED_overrun_OutHigh
  );

  modport slave (
    input  SC_SCHED_startButton_InLow,
    input  SC_SCHED_leftButton_InLow,
    input  SC_SCHED_rightButton_InLow,
    input  SC_SCHED_tickEnable_InHigh,
    output SC_SCHED_startButton_OutLow,
    output SC_SCHED_leftButton_OutLow,
    output SC_SCHED_rightButton_OutLow,
    output SC_SCHED_T0_OutLow,
    output SC_SCHED_busy_OutHigh,
    output SC_SCHED_overrun_OutHigh
  );

endinterface

// File: rtl/sc_point_request_scheduler_debouncer.sv
// Two-flop synchroniser plus counting debouncer for one active-low button.
// press_o is a one-cycle pulse issued when the debounced level falls 1->0;
// releases produce nothing, so a held button yields a single press.
module sc_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_raw_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronise, then accept a level change only after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= button_raw_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
        press_q <= level_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sc_point_request_scheduler.sv
// Request scheduler in front of the point state machine: debounces the three
// buttons, generates the periodic move tick and serialises all four request
// sources into one-cycle active-low pulses separated by a guard gap.
//
//   state         | meaning
//   --------------+-----------------------------------------------------
//   STATE_IDLE_0  | waiting; latch highest-priority pending source
//   STATE_GRANT_0 | winner's request output low for exactly one cycle
//   STATE_GAP_0   | GAP_CYCLES quiet cycles so the state machine settles
module sc_point_request_scheduler
  import sc_point_request_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_PERIOD     = 50000000,
  parameter int GAP_CYCLES      = 3
) (
  input  logic                                SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                                SC_STATEMACHINEPOINT_RESET_InHigh,
  sc_point_request_scheduler_if.slave         sched_if
);

  localparam int TICK_W = $clog2(TICK_PERIOD);
  localparam int GAP_W  = $clog2(GAP_CYCLES);

  logic              clk;
  logic              rst;
  logic [2:0]        raw_btn;
  logic [2:0]        press;

  sched_state_t      state_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [3:0]        req_n_q;
  logic              busy_q;

  logic [3:0]        pend_q, pend_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              overrun_q, overrun_d;
  logic              tick_wrap;
  logic              grant_take;
  src_idx_t          winner;

  assign clk = SC_STATEMACHINEPOINT_CLOCK_50;
  assign rst = SC_STATEMACHINEPOINT_RESET_InHigh;

  assign raw_btn[SRC_START] = sched_if.SC_SCHED_startButton_InLow;
  assign raw_btn[SRC_LEFT]  = sched_if.SC_SCHED_leftButton_InLow;
  assign raw_btn[SRC_RIGHT] = sched_if.SC_SCHED_rightButton_InLow;

  for (genvar g = 0; g < 3; g++) begin : g_btn
    sc_button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_i        (clk),
      .rst_i        (rst),
      .button_raw_i (raw_btn[g]),
      .press_o      (press[g])
    );
  end

  assign grant_take = (state_q == STATE_IDLE_0) && (|pend_q);
  assign winner     = pick_winner(pend_q);

  // Tick counter: free-runs while enabled, restarted by a start grant so the
  // first move after a start is a full period away.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_wrap  = 1'b0;
    if (grant_take && (winner == SRC_START)) begin
      tick_cnt_d = '0;
    end else if (sched_if.SC_SCHED_tickEnable_InHigh) begin
      if (tick_cnt_q == TICK_W'(TICK_PERIOD - 1)) begin
        tick_cnt_d = '0;
        tick_wrap  = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // Pending flags: a grant clears its source, a new event sets it; set wins,
  // so an event coinciding with its own grant is served again later.
  always_comb begin
    pend_d = pend_q;
    if (grant_take) pend_d[winner] = 1'b0;
    pend_d[2:0] = pend_d[2:0] | press;
    if (tick_wrap) pend_d[SRC_TICK] = 1'b1;
    overrun_d = overrun_q |
                (tick_wrap && pend_q[SRC_TICK] &&
                 !(grant_take && (winner == SRC_TICK)));
  end

  // Pending flags, tick counter and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      tick_cnt_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      tick_cnt_q <= tick_cnt_d;
      overrun_q  <= overrun_d;
    end
  end

  // Arbiter FSM with registered request and busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= STATE_IDLE_0;
      gap_cnt_q <= '0;
      req_n_q   <= '1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        STATE_IDLE_0: begin
          if (grant_take) begin
            state_q <= STATE_GRANT_0;
            req_n_q <= ~(4'b0001 << winner);
            busy_q  <= 1'b1;
          end
        end
        STATE_GRANT_0: begin
          state_q   <= STATE_GAP_0;
          req_n_q   <= '1;
          gap_cnt_q <= '0;
        end
        STATE_GAP_0: begin
          if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
            state_q <= STATE_IDLE_0;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= STATE_IDLE_0;
          req_n_q <= '1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sched_if.SC_SCHED_startButton_OutLow = req_n_q[SRC_START];
  assign sched_if.SC_SCHED_leftButton_OutLow  = req_n_q[SRC_LEFT];
  assign sched_if.SC_SCHED_rightButton_OutLow = req_n_q[SRC_RIGHT];
  assign sched_if.SC_SCHED_T0_OutLow          = req_n_q[SRC_TICK];
  assign sched_if.SC_SCHED_busy_OutHigh       = busy_q;
  assign sched_if.SC_SCHED_overrun_OutHigh    = overrun_q;

endmodule

// File: doc/sc_point_request_scheduler.md
Name: sc_point_request_scheduler

Overview:
- Sits between the raw board inputs and the point state machine, which drives clear/load0/shiftselection of the point shift-register datapath.
- Synchronises and debounces the three active-low buttons (start/left/right) and generates the periodic move tick (T0).
- Arbitrates all four request sources so only one one-cycle active-low request reaches the state machine at a time.
- Enforces a guard gap after each request so the state machine can return to its check state before the next request.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a level change (>=1).
- TICK_PERIOD, 50000000, clock cycles between move ticks (>=2).
- GAP_CYCLES, 3, idle cycles after each grant before the next grant (>=2).

Ports:
- SC_STATEMACHINEPOINT_CLOCK_50  in  1  system clock.
- SC_STATEMACHINEPOINT_RESET_InHigh  in  1  reset.
- SC_SCHED_startButton_InLow  in  1  raw start button, active low, asynchronous.
- SC_SCHED_leftButton_InLow  in  1  raw left button, active low, asynchronous.
- SC_SCHED_rightButton_InLow  in  1  raw right button, active low, asynchronous.
- SC_SCHED_tickEnable_InHigh  in  1  tick counter runs when 1, holds when 0.
- SC_SCHED_startButton_OutLow  out  1  start request to state machine, one-cycle low pulse.
- SC_SCHED_leftButton_OutLow  out  1  left request, one-cycle low pulse.
- SC_SCHED_rightButton_OutLow  out  1  right request, one-cycle low pulse.
- SC_SCHED_T0_OutLow  out  1  move-tick request, one-cycle low pulse.
- SC_SCHED_busy_OutHigh  out  1  high during GRANT and GAP states.
- SC_SCHED_overrun_OutHigh  out  1  sticky; a tick arrived while a tick was still pending.

Behaviour:
- Reset: SC_STATEMACHINEPOINT_RESET_InHigh, asynchronous, active-high; clock SC_STATEMACHINEPOINT_CLOCK_50.
- Reset values: all four request outputs 1, busy 0, overrun 0, pending flags 0, counters 0, debounced levels 1, FSM in IDLE.
- Reset asserted mid-grant or mid-gap aborts immediately to the reset values.
- Synchroniser: two flops per button, reset to 1.
- Debounce, per button:
  - Counter clears whenever the synchronised sample equals the debounced level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES the debounced level toggles and the counter clears.
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
- Press event: debounced level 1->0 sets that button's pending flag on the next edge. Releases generate nothing. Holding a button produces exactly one event.
- Tick:
  - Counter width $clog2(TICK_PERIOD); counts 0..TICK_PERIOD-1 while enabled, then wraps to 0.
  - Wrap sets tick pending. If tick pending is already 1, overrun is set (sticky until reset) and the tick is merged.
  - A start grant reloads the tick counter to 0.
- Arbiter FSM states: IDLE, GRANT, GAP.
  - IDLE: if any pending flag is set, latch the winner (priority start > left > right > tick), clear its pending flag, go to GRANT.
  - GRANT (exactly 1 cycle): drive the winner's output low, all others high; go to GAP.
  - GAP: count GAP_CYCLES cycles with all outputs high, then go to IDLE.
  - busy = (state != IDLE).
- Latency: raw press stable from edge 0 to grant output low = DEBOUNCE_CYCLES+4 edges when idle (2 sync + DEBOUNCE_CYCLES + 1 pending + 1 grant).
- Back-to-back grants are spaced exactly GAP_CYCLES+2 cycles apart: 1 grant cycle, GAP_CYCLES gap cycles, 1 IDLE cycle.
- Simultaneous events:
  - All flags are captured together and served in priority order.
  - A new event for the source being granted in the same cycle its flag clears re-sets the flag (set wins over clear), so it is served again later.
  - Repeat events of a source already pending merge. This is silent for buttons and flagged via overrun for the tick.
- Never more than one request output low in any cycle.

Decomposition:
- Shared package holds:
  - State encodings (STATE_IDLE_0=0, STATE_GRANT_0=1, STATE_GAP_0=2).
  - Source index constants (SRC_START=0, SRC_LEFT=1, SRC_RIGHT=2, SRC_TICK=3).
- One sub-module, sc_button_debouncer (synchroniser + debounce + press-event output), instantiated three times.
- Tick counter and arbiter stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, TICK_PERIOD=20, GAP_CYCLES=3):
- Reset release, no stimulus, tickEnable=0 for 100 cycles -> all outputs high, busy 0, overrun 0.
- Left raw low at edge 10, held 30 cycles -> leftButton_OutLow low only at edge 18; no second pulse; busy high edges 18-21.
- Start and right raw low at the same edge 0 -> start pulse at edge 8, right pulse at edge 13; never both low together.
- Left raw bounce (low 2 cycles, high 1, repeated 5x) then high -> no output pulse.
- tickEnable=1 with continuous pending left presses blocking the arbiter -> two tick wraps while tick pending sets overrun=1; exactly one T0 pulse is issued once served.
- Reset asserted during GAP after a start grant -> outputs high and busy 0 immediately (asynchronously); pending flags cleared; no pulse after release.
